// File: rtl/irq_sequencer.sv
// rtl/irq_sequencer.sv - 6502 reset/NMI/IRQ/BRK entry sequencer (stack pushes, vector fetch, PC/S/I handoff)
module irq_sequencer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        i_flag,
    input  logic        brk_req,
    input  logic        instr_boundary,
    input  logic [15:0] pc_in,
    input  logic [7:0]  p_in,
    input  logic [7:0]  sp_in,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_rw,
    output logic [15:0] pc_out,
    output logic        pc_ld,
    output logic [7:0]  sp_out,
    output logic        sp_ld,
    output logic        set_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH_H,
        S_PUSH_L,
        S_PUSH_P,
        S_VEC_LO,
        S_VEC_HI,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        SRC_RST,
        SRC_NMI,
        SRC_IRQ,
        SRC_BRK
    } src_t;

    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_RST = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;

    state_t state_q, state_d;
    src_t   src_q, accept_src;
    logic   accept;

    logic [SYNC_STAGES-1:0] nmi_sync_q;
    logic [SYNC_STAGES-1:0] irq_sync_q;
    logic nmi_sync, irq_sync;
    logic nmi_prev_q;
    logic nmi_fall;
    logic nmi_pend_q;
    logic nmi_now;
    logic nmi_take;
    logic irq_act;
    logic rst_pend_q;

    logic [15:0] pc_q;
    logic [7:0]  p_q;
    logic [7:0]  sp_q;
    logic [15:0] vec_q;
    logic [15:0] vec_sel;
    logic [7:0]  lo_q;
    logic [7:0]  p_push;

    // Synchronize the asynchronous interrupt pins; idle level is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_sync_q <= '1;
            irq_sync_q <= '1;
        end else begin
            nmi_sync_q[0] <= nmi_n;
            irq_sync_q[0] <= irq_n;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                nmi_sync_q[i] <= nmi_sync_q[i-1];
                irq_sync_q[i] <= irq_sync_q[i-1];
            end
        end
    end

    assign nmi_sync = nmi_sync_q[SYNC_STAGES-1];
    assign irq_sync = irq_sync_q[SYNC_STAGES-1];
    assign nmi_fall = nmi_prev_q & ~nmi_sync;
    // An edge seen this very cycle counts as pending, so a late NMI can still hijack the vector
    assign nmi_now  = nmi_pend_q | nmi_fall;
    assign irq_act  = ~irq_sync & ~i_flag;
    assign nmi_take = (state_q == S_VEC_LO) && (src_q != SRC_RST) && nmi_now;

    // NMI edge detector and pending latch; consuming the NMI vector clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_prev_q <= 1'b1;
            nmi_pend_q <= 1'b0;
        end else begin
            nmi_prev_q <= nmi_sync;
            if (nmi_take) begin
                nmi_pend_q <= 1'b0;
            end else if (nmi_fall) begin
                nmi_pend_q <= 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: acceptance priority reset > NMI > IRQ > BRK, then a fixed six-cycle walk
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        accept_src = SRC_BRK;
        case (state_q)
            S_IDLE: begin
                if (rst_pend_q) begin
                    accept     = 1'b1;
                    accept_src = SRC_RST;
                end else if (instr_boundary) begin
                    if (nmi_now) begin
                        accept     = 1'b1;
                        accept_src = SRC_NMI;
                    end else if (irq_act) begin
                        accept     = 1'b1;
                        accept_src = SRC_IRQ;
                    end else if (brk_req) begin
                        accept     = 1'b1;
                        accept_src = SRC_BRK;
                    end
                end
                if (accept) begin
                    state_d = S_PUSH_H;
                end
            end
            S_PUSH_H: state_d = S_PUSH_L;
            S_PUSH_L: state_d = S_PUSH_P;
            S_PUSH_P: state_d = S_VEC_LO;
            S_VEC_LO: state_d = S_VEC_HI;
            S_VEC_HI: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Vector choice made in VEC_LO; reset always wins, then any pending NMI
    always_comb begin
        vec_sel = VEC_IRQ;
        if (src_q == SRC_RST) begin
            vec_sel = VEC_RST;
        end else if (nmi_now) begin
            vec_sel = VEC_NMI;
        end
    end

    // Entry context: latched at acceptance, stack pointer walks down through the pushes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q      <= SRC_RST;
            pc_q       <= 16'h0000;
            p_q        <= 8'h00;
            sp_q       <= 8'h00;
            vec_q      <= 16'h0000;
            lo_q       <= 8'h00;
            rst_pend_q <= 1'b1;
        end else begin
            if (accept) begin
                src_q <= accept_src;
                pc_q  <= pc_in;
                p_q   <= p_in;
                if (accept_src != SRC_RST) begin
                    sp_q <= sp_in;
                end
            end
            if (state_q == S_PUSH_H || state_q == S_PUSH_L || state_q == S_PUSH_P) begin
                sp_q <= sp_q - 8'd1;
            end
            if (state_q == S_VEC_LO) begin
                vec_q <= vec_sel;
            end
            if (state_q == S_VEC_HI) begin
                lo_q <= mem_rdata;
            end
            if (state_q == S_DONE && src_q == SRC_RST) begin
                rst_pend_q <= 1'b0;
            end
        end
    end

    // Pushed status: bit5 always set, B set only for BRK
    assign p_push = (src_q == SRC_BRK) ? (p_q | 8'h30) : ((p_q | 8'h20) & 8'hEF);

    // Bus and strobe decode; reset entry turns the pushes into dummy reads
    always_comb begin
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        mem_rw    = 1'b1;
        pc_out    = 16'h0000;
        pc_ld     = 1'b0;
        sp_out    = 8'h00;
        sp_ld     = 1'b0;
        set_i     = 1'b0;
        case (state_q)
            S_PUSH_H: begin
                mem_addr = {8'h01, sp_q};
                if (src_q != SRC_RST) begin
                    mem_rw    = 1'b0;
                    mem_wdata = pc_q[15:8];
                end
            end
            S_PUSH_L: begin
                mem_addr = {8'h01, sp_q};
                if (src_q != SRC_RST) begin
                    mem_rw    = 1'b0;
                    mem_wdata = pc_q[7:0];
                end
            end
            S_PUSH_P: begin
                mem_addr = {8'h01, sp_q};
                if (src_q != SRC_RST) begin
                    mem_rw    = 1'b0;
                    mem_wdata = p_push;
                end
            end
            S_VEC_LO: begin
                mem_addr = vec_sel;
            end
            S_VEC_HI: begin
                mem_addr = vec_q + 16'd1;
            end
            S_DONE: begin
                pc_out = {mem_rdata, lo_q};
                pc_ld  = 1'b1;
                sp_out = sp_q;
                sp_ld  = 1'b1;
                set_i  = 1'b1;
            end
            default: begin
                mem_addr = 16'h0000;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE) | rst_pend_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// tb/tb_irq_sequencer.sv - self-checking bench for irq_sequencer
module tb_irq_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        nmi_n, irq_n, i_flag, brk_req, instr_boundary;
    logic [15:0] pc_in;
    logic [7:0]  p_in, sp_in;
    logic [7:0]  mem_rdata = 8'h00;
    logic        busy, mem_rw, pc_ld, sp_ld, set_i;
    logic [15:0] mem_addr, pc_out;
    logic [7:0]  mem_wdata, sp_out;

    localparam int K_RST = 0, K_NMI = 1, K_IRQ = 2, K_BRK = 3;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  vec_rom [6];
    logic [28:0] act_bus [7];
    logic [28:0] exp_bus [7];
    logic [15:0] act_pc, exp_pc;
    logic [7:0]  act_sp, exp_sp;

    irq_sequencer #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .nmi_n(nmi_n), .irq_n(irq_n), .i_flag(i_flag),
        .brk_req(brk_req), .instr_boundary(instr_boundary), .pc_in(pc_in), .p_in(p_in),
        .sp_in(sp_in), .mem_rdata(mem_rdata), .busy(busy), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rw(mem_rw), .pc_out(pc_out), .pc_ld(pc_ld),
        .sp_out(sp_out), .sp_ld(sp_ld), .set_i(set_i)
    );

    always #5 clk = ~clk;

    // Vector ROM at FFFA..FFFF, registered read (data one cycle after address)
    always @(posedge clk)
        mem_rdata <= (mem_addr >= 16'hFFFA) ? vec_rom[3'(mem_addr - 16'hFFFA)] : 8'h00;

    function automatic logic [7:0] rom(input logic [15:0] a);
        return vec_rom[3'(a - 16'hFFFA)];
    endfunction

    // Expected per-cycle bus trace {addr, wdata, rw, busy, pc_ld, sp_ld, set_i} for one entry
    task automatic model_entry(input int kind, input logic [15:0] pc, input logic [7:0] sp,
                               input logic [7:0] p, input bit hijack);
        logic [15:0] vec;
        logic [7:0]  s0, sa;
        logic [7:0]  data [3];
        vec = (kind == K_RST) ? 16'hFFFC : ((kind == K_NMI || hijack) ? 16'hFFFA : 16'hFFFE);
        s0  = (kind == K_RST) ? 8'h00 : sp;
        data[0] = pc[15:8];
        data[1] = pc[7:0];
        data[2] = (kind == K_BRK) ? (p | 8'h30) : ((p | 8'h20) & 8'hEF);
        for (int k = 0; k < 3; k++) begin
            sa = s0 - 8'(k);
            exp_bus[k] = {8'h01, sa, (kind == K_RST) ? 8'h00 : data[k], kind == K_RST, 1'b1, 3'b000};
        end
        exp_bus[3] = {vec, 8'h00, 1'b1, 1'b1, 3'b000};
        exp_bus[4] = {vec + 16'd1, 8'h00, 1'b1, 1'b1, 3'b000};
        exp_bus[5] = {16'h0000, 8'h00, 1'b1, 1'b1, 3'b111};
        exp_bus[6] = {16'h0000, 8'h00, 1'b1, 1'b0, 3'b000};
        exp_pc = {rom(vec + 16'd1), rom(vec)};
        exp_sp = s0 - 8'd3;
    endtask

    // Record seven cycles starting at the first active bus cycle; optional NMI drop at cycle nmi_at
    task automatic capture(input int nmi_at, output bit ok);
        int t;
        t = 0;
        while (!(busy === 1'b1 && mem_addr != 16'h0000) && t < 60) begin
            @(negedge clk);
            t++;
        end
        ok = (t < 60);
        for (int i = 0; i < 7; i++) begin
            act_bus[i] = {mem_addr, mem_wdata, mem_rw, busy, pc_ld, sp_ld, set_i};
            if (i == 5) begin
                act_pc = pc_out;
                act_sp = sp_out;
            end
            if (i == nmi_at) nmi_n = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulse_boundary(input bit brk);
        instr_boundary = 1'b1;
        brk_req = brk;
        @(negedge clk);
        instr_boundary = 1'b0;
        brk_req = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, mem_addr, mem_wdata, mem_rw, pc_ld, sp_ld, set_i, pc_out, sp_out} !==
            {1'b1, 16'h0, 8'h0, 1'b1, 3'b000, 16'h0, 8'h0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b addr=%h wd=%h rw=%b strb=%b%b%b pc=%h sp=%h required 1 0000 00 1 000 0000 00",
                     busy, mem_addr, mem_wdata, mem_rw, pc_ld, sp_ld, set_i, pc_out, sp_out);
        end
        rst_n = 1'b1;
        model_entry(K_RST, 16'h0, 8'h0, 8'h0, 1'b0);
        capture(-1, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL reset_start: got timeout required entry"); end
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (act_bus[i] !== exp_bus[i]) begin
                n_fail++;
                $display("FAIL reset_bus[%0d]: got %h required %h", i, act_bus[i], exp_bus[i]);
            end
        end
        n_checks++;
        if ({act_pc, act_sp} !== {16'h1234, 8'hFD}) begin
            n_fail++;
            $display("FAIL reset_pc_sp: got %h/%h required 1234/fd", act_pc, act_sp);
        end
    endtask

    task automatic test_irq();
        bit ok;
        vec_rom[4] = 8'h00; vec_rom[5] = 8'h80;
        pc_in = 16'hC005; sp_in = 8'hFD; p_in = 8'hA1; i_flag = 1'b0; irq_n = 1'b0;
        repeat (3) @(negedge clk);
        pulse_boundary(1'b0);
        model_entry(K_IRQ, pc_in, sp_in, p_in, 1'b0);
        capture(-1, ok);
        irq_n = 1'b1;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL irq_start: got timeout required entry"); end
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (act_bus[i] !== exp_bus[i]) begin
                n_fail++;
                $display("FAIL irq_bus[%0d]: got %h required %h", i, act_bus[i], exp_bus[i]);
            end
        end
        n_checks++;
        if ({act_pc, act_sp} !== {16'h8000, 8'hFA}) begin
            n_fail++;
            $display("FAIL irq_pc_sp: got %h/%h required 8000/fa", act_pc, act_sp);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_brk();
        bit ok;
        pc_in = 16'h0302; sp_in = 8'hFA; p_in = 8'h20;
        pulse_boundary(1'b1);
        model_entry(K_BRK, pc_in, sp_in, p_in, 1'b0);
        capture(-1, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL brk_start: got timeout required entry"); end
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (act_bus[i] !== exp_bus[i]) begin
                n_fail++;
                $display("FAIL brk_bus[%0d]: got %h required %h", i, act_bus[i], exp_bus[i]);
            end
        end
        n_checks++;
        if (act_bus[2][12:5] !== 8'h30 || act_bus[3][28:13] !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL brk_p_vec: got %h/%h required 30/fffe", act_bus[2][12:5], act_bus[3][28:13]);
        end
        n_checks++;
        if ({act_pc, act_sp} !== {exp_pc, exp_sp}) begin
            n_fail++;
            $display("FAIL brk_pc_sp: got %h/%h required %h/%h", act_pc, act_sp, exp_pc, exp_sp);
        end
    endtask

    task automatic test_masked_irq();
        i_flag = 1'b1; irq_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int b = 0; b < 10; b++) begin
            pulse_boundary(1'b0);
            n_checks++;
            if (busy !== 1'b0 || mem_rw !== 1'b1) begin
                n_fail++;
                $display("FAIL masked_irq[%0d]: got busy=%b rw=%b required 0/1", b, busy, mem_rw);
            end
        end
        irq_n = 1'b1;
        repeat (4) @(negedge clk);
        i_flag = 1'b0;
        brk_req = 1'b1;
        repeat (3) @(negedge clk);
        brk_req = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL brk_no_boundary: got busy=%b required 0", busy); end
        irq_n = 1'b0;
        repeat (2) @(negedge clk);
        irq_n = 1'b1;
        repeat (4) @(negedge clk);
        pulse_boundary(1'b0);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL irq_dropped: got busy=%b required 0", busy); end
    endtask

    task automatic test_nmi_hijack();
        bit ok;
        vec_rom[0] = 8'h00; vec_rom[1] = 8'h90;
        pc_in = 16'h4567; sp_in = 8'hF0; p_in = 8'h04; i_flag = 1'b0; irq_n = 1'b0;
        repeat (3) @(negedge clk);
        pulse_boundary(1'b0);
        model_entry(K_IRQ, pc_in, sp_in, p_in, 1'b1);
        capture(1, ok);
        irq_n = 1'b1;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL hijack_start: got timeout required entry"); end
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (act_bus[i] !== exp_bus[i]) begin
                n_fail++;
                $display("FAIL hijack_bus[%0d]: got %h required %h", i, act_bus[i], exp_bus[i]);
            end
        end
        n_checks++;
        if ({act_pc, act_sp} !== {16'h9000, 8'hED}) begin
            n_fail++;
            $display("FAIL hijack_pc_sp: got %h/%h required 9000/ed", act_pc, act_sp);
        end
        nmi_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            pulse_boundary(1'b0);
            n_checks++;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL hijack_no_second[%0d]: got busy=%b required 0", b, busy); end
        end
    endtask

    task automatic test_reset_mid_nmi();
        bit ok;
        pc_in = 16'hABCD; sp_in = 8'h80; p_in = 8'h00;
        nmi_n = 1'b0;
        repeat (4) @(negedge clk);
        nmi_n = 1'b1;
        pulse_boundary(1'b0);
        repeat (2) @(negedge clk);
        n_checks++;
        if (mem_rw !== 1'b0 || mem_addr !== 16'h017E) begin
            n_fail++;
            $display("FAIL nmi_push_p: got rw=%b addr=%h required 0/017e", mem_rw, mem_addr);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_rw, busy, mem_addr} !== {1'b1, 1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL abort_now: got rw=%b busy=%b addr=%h required 1/1/0000", mem_rw, busy, mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_entry(K_RST, 16'h0, 8'h0, 8'h0, 1'b0);
        capture(-1, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rerst_start: got timeout required entry"); end
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (act_bus[i] !== exp_bus[i]) begin
                n_fail++;
                $display("FAIL rerst_bus[%0d]: got %h required %h", i, act_bus[i], exp_bus[i]);
            end
        end
        n_checks++;
        if ({act_pc, act_sp} !== {16'h1234, 8'hFD}) begin
            n_fail++;
            $display("FAIL rerst_pc_sp: got %h/%h required 1234/fd", act_pc, act_sp);
        end
    endtask

    task automatic test_random();
        bit ok, nmi_b, irq_b, mask_b, brk_b;
        int kind, n_ent;
        for (int it = 0; it < 16; it++) begin
            nmi_b  = 1'($urandom_range(0, 1));
            irq_b  = 1'($urandom_range(0, 1));
            mask_b = 1'($urandom_range(0, 1));
            brk_b  = 1'($urandom_range(0, 1));
            if (!nmi_b && !(irq_b && !mask_b)) brk_b = 1'b1;
            kind  = nmi_b ? K_NMI : ((irq_b && !mask_b) ? K_IRQ : K_BRK);
            n_ent = (kind == K_NMI && irq_b && !mask_b) ? 2 : 1;
            for (int k = 0; k < 6; k++) vec_rom[k] = 8'($urandom);
            i_flag = mask_b;
            irq_n  = !irq_b;
            nmi_n  = !nmi_b;
            repeat (4) @(negedge clk);
            nmi_n = 1'b1;
            for (int e = 0; e < n_ent; e++) begin
                pc_in = 16'($urandom); sp_in = 8'($urandom); p_in = 8'($urandom);
                pulse_boundary(brk_b);
                model_entry((e == 0) ? kind : K_IRQ, pc_in, sp_in, p_in, 1'b0);
                capture(-1, ok);
                n_checks++;
                if (!ok) begin n_fail++; $display("FAIL rand%0d_%0d_start: got timeout required entry", it, e); end
                for (int i = 0; i < 7; i++) begin
                    n_checks++;
                    if (act_bus[i] !== exp_bus[i]) begin
                        n_fail++;
                        $display("FAIL rand%0d_%0d_bus[%0d]: got %h required %h", it, e, i, act_bus[i], exp_bus[i]);
                    end
                end
                n_checks++;
                if ({act_pc, act_sp} !== {exp_pc, exp_sp}) begin
                    n_fail++;
                    $display("FAIL rand%0d_%0d_pc_sp: got %h/%h required %h/%h", it, e, act_pc, act_sp, exp_pc, exp_sp);
                end
            end
            irq_n = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; nmi_n = 1'b1; irq_n = 1'b1; i_flag = 1'b0; brk_req = 1'b0;
        instr_boundary = 1'b0; pc_in = 16'h0; p_in = 8'h0; sp_in = 8'h0;
        vec_rom[0] = 8'h00; vec_rom[1] = 8'h00; vec_rom[2] = 8'h34;
        vec_rom[3] = 8'h12; vec_rom[4] = 8'h00; vec_rom[5] = 8'h00;
        test_reset();
        test_irq();
        test_brk();
        test_masked_irq();
        test_nmi_hijack();
        test_reset_mid_nmi();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Sequences the 6502 interrupt, BRK and reset entry: pushes PCH, PCL and P to page-1 stack, fetches the vector, then hands the new PC, S and I flag back to the datapath.
- Sits beside the main control FSM, which asserts instr_boundary at fetch1 and stalls while busy=1.
- While busy, this block owns the memory address/data/rw lines; control's muxes select it.

Parameters:
SYNC_STAGES, 2, synchronizer flops on nmi_n and irq_n (legal range 1..3)

Ports:
clk  input  1  system clock, all flops rising-edge
rst_n  input  1  asynchronous active-low reset
nmi_n  input  1  external NMI, falling-edge triggered, asynchronous
irq_n  input  1  external IRQ, level-low, asynchronous
i_flag  input  1  P[2] from datapath, masks IRQ
brk_req  input  1  control has decoded BRK; valid only with instr_boundary
instr_boundary  input  1  control is at fetch1 and will accept entry this cycle
pc_in  input  16  PC to push (control has already advanced past the BRK padding byte)
p_in  input  8  status register to push
sp_in  input  8  current S
mem_rdata  input  8  memory read data, valid one cycle after the address
busy  output  1  sequence in progress or reset pending; control stalls
mem_addr  output  16  bus address while busy
mem_wdata  output  8  push data
mem_rw  output  1  1=read, 0=write
pc_out  output  16  new PC, valid with pc_ld
pc_ld  output  1  one-cycle load strobe for PCH/PCL
sp_out  output  8  new S, valid with sp_ld
sp_ld  output  1  one-cycle load strobe for S
set_i  output  1  one-cycle strobe: set P[2]

Behaviour:
- Reset (rst_n=0): state=IDLE, rst_pend=1, nmi_pend=0, internal sp=8'h00. Outputs: mem_addr=0, mem_wdata=0, mem_rw=1, pc_ld=0, sp_ld=0, set_i=0, pc_out=0, sp_out=0. busy=1, since busy=(state!=IDLE)|rst_pend.
- nmi_n and irq_n each pass through SYNC_STAGES flops that reset to 1.
- NMI: a 1->0 transition of the synchronized nmi_n sets nmi_pend. nmi_pend holds until VEC_LO issues an NMI vector. A second edge while pending is lost.
- IRQ: irq_act = ~irq_sync & ~i_flag, sampled at acceptance only; not latched.
- Acceptance in IDLE:
  - rst_pend=1: start immediately, without waiting for instr_boundary.
  - Otherwise, only when instr_boundary=1. Priority: nmi_pend > irq_act > brk_req. If none are active, stay IDLE.
  - On acceptance, latch pc_in, sp_in (except reset) and p_in. Latch src in {RST, NMI, IRQ, BRK}.
- States, one cycle each: IDLE -> PUSH_H -> PUSH_L -> PUSH_P -> VEC_LO -> VEC_HI -> DONE -> IDLE. Entry takes 6 cycles after the acceptance edge.
- PUSH_H, PUSH_L, PUSH_P:
  - mem_addr = {8'h01, sp}; sp decrements (mod 256) on exit.
  - Data pushed: PCH, then PCL, then P_push.
  - P_push = p_in with bit5=1 and bit4=1 for BRK, bit4=0 for IRQ/NMI.
  - For RST these cycles are reads (mem_rw=1, mem_wdata=0). Starting from sp=8'h00, sp ends at 8'hFD.
  - For all other sources, mem_rw=0.
- VEC_LO: choose the vector. Order: RST -> FFFC; else nmi_pend -> FFFA; else FFFE.
  - NMI hijack: an NMI that went pending during the pushes of an IRQ/BRK redirects the vector to FFFA.
  - Clear nmi_pend when FFFA is chosen.
  - mem_addr = vector, mem_rw=1.
- VEC_HI: mem_addr = vector+1; capture lo = mem_rdata.
- DONE:
  - pc_out = {mem_rdata, lo}, pc_ld=1.
  - sp_out = sp, sp_ld=1.
  - set_i=1.
  - If src=RST, clear rst_pend.
  - mem_addr=0, mem_rw=1.
- Outside the active states, mem_addr=0, mem_rw=1, and all strobes are 0.
- rst_n asserted mid-sequence aborts immediately to the reset values; the sequence restarts as RST after release.
- brk_req without instr_boundary is ignored. An IRQ that drops before acceptance is not taken.
- If NMI and IRQ are both active at a boundary, NMI is taken; IRQ remains visible at the next boundary if still asserted and unmasked.

Test Plan:
- Release rst_n; memory FFFC=34, FFFD=12 -> 3 stack reads at 0100, 01FF, 01FE. DONE: pc_out=1234, sp_out=FD, pc_ld=sp_ld=set_i=1 for 1 cycle. busy falls the cycle after DONE.
- IRQ with i_flag=0, pc_in=C005, sp_in=FD, p_in=A1, FFFE/F=00,80 -> writes 01FD=C0, 01FC=05, 01FB=A1 (B=0). pc_out=8000, sp_out=FA.
- BRK at boundary, p_in=20, pc_in=0302 -> 3rd write has data 30. Vector FFFE.
- IRQ held with i_flag=1 across 10 boundaries -> busy stays 0, no bus writes.
- NMI falling edge during PUSH_L of an IRQ entry -> vector fetch from FFFA/FFFB, nmi_pend cleared, no second NMI entry.
- rst_n pulsed low during PUSH_P of an NMI entry -> mem_rw=1 immediately. After release, a full reset sequence runs and sp_out=FD.
